fpu_seq: RTL

Parametrised multi-cycle FPU sequencer between the core's execute stage and the floating-point arithmetic units. It accepts one operation at a time, registers the operands and drives them to the external add/mul/div/sqrt units. It waits a per-operation latency, captures the selected result and pulses `ready`. Sign-injection and compare operations are computed inside the block in a single cycle.

---
 rtl/fpu_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle sequencer between the execute stage and the external
// floating-point add/mul/div/sqrt units. One operation is in flight at a time.
// Operands are registered and driven to the units. The selected unit result is
// captured after a per-op latency and reported with a one-cycle ready pulse.
// Sign injection and compares are evaluated locally with a latency of one.
module fpu_seq #(
  parameter int W        = 32,
  parameter int EW       = 8,
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 8,
  parameter int LAT_SQRT = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [3:0]   i_ctl,
  input  logic [W-1:0] i_x1,
  input  logic [W-1:0] i_x2,
  output logic         o_busy,
  output logic         o_ready,
  output logic [W-1:0] o_y,
  output logic [W-1:0] o_u_x1,
  output logic [W-1:0] o_u_x2,
  input  logic [W-1:0] i_fadd_y,
  input  logic [W-1:0] i_fmul_y,
  input  logic [W-1:0] i_fdiv_y,
  input  logic [W-1:0] i_fsqrt_y
);

  localparam int MW      = W - 1 - EW;
  localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_DS  = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
  localparam int LAT_MAX = (LAT_AM > LAT_DS) ? LAT_AM : LAT_DS;
  localparam int CW      = $clog2(LAT_MAX + 1);

  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,
    OP_FADD   = 4'd1,
    OP_FSUB   = 4'd2,
    OP_FMUL   = 4'd3,
    OP_FDIV   = 4'd4,
    OP_FSQRT  = 4'd5,
    OP_FSGNJ  = 4'd6,
    OP_FSGNJN = 4'd7,
    OP_FSGNJX = 4'd8,
    OP_FEQ    = 4'd9,
    OP_FLT    = 4'd10,
    OP_FLE    = 4'd11
  } opcode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  opcode_t        r_op;
  opcode_t        w_ctlOp;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_issueLat;
  logic [W-1:0]   r_ux1;
  logic [W-1:0]   r_ux2;
  logic [W-1:0]   r_y;
  logic           r_ready;
  logic           w_legal;
  logic           w_issue;
  logic           w_done;
  logic [W-1:0]   w_result;

  logic           w_sign1;
  logic           w_sign2;
  logic [EW-1:0]  w_exp1;
  logic [EW-1:0]  w_exp2;
  logic [MW-1:0]  w_man1;
  logic [MW-1:0]  w_man2;
  logic [W-2:0]   w_mag1;
  logic [W-2:0]   w_mag2;
  logic           w_anyNan;
  logic           w_bothZero;
  logic           w_eq;
  logic           w_lt;
  logic           w_le;

  assign w_ctlOp = opcode_t'(i_ctl);
  assign w_legal = (i_ctl >= 4'd1) && (i_ctl <= 4'd11);
  assign w_issue = (r_state == S_IDLE) && w_legal;
  assign w_done  = (r_state == S_BUSY) && (r_count == CW'(1));

  assign o_busy  = (r_state == S_BUSY);
  assign o_ready = r_ready;
  assign o_y     = r_y;
  assign o_u_x1  = r_ux1;
  assign o_u_x2  = r_ux2;

  // Latency to load into the countdown when an op is accepted
  always_comb begin
    w_issueLat = CW'(1);
    case (w_ctlOp)
      OP_FADD, OP_FSUB: w_issueLat = CW'(LAT_ADD);
      OP_FMUL:          w_issueLat = CW'(LAT_MUL);
      OP_FDIV:          w_issueLat = CW'(LAT_DIV);
      OP_FSQRT:         w_issueLat = CW'(LAT_SQRT);
      default:          w_issueLat = CW'(1);
    endcase
  end

  // State register; reset drops any op in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next state: accept a legal op when idle, return to idle on the final count
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_nextState = S_BUSY;
      S_BUSY:  if (w_done)  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Operand capture, latency countdown, result capture and ready pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op    <= OP_NONE;
      r_count <= '0;
      r_ux1   <= '0;
      r_ux2   <= '0;
      r_y     <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (w_issue) begin
        r_op    <= w_ctlOp;
        r_count <= w_issueLat;
        r_ux1   <= i_x1;
        r_ux2   <= (w_ctlOp == OP_FSUB) ? {~i_x2[W-1], i_x2[W-2:0]} : i_x2;
      end else if (r_state == S_BUSY) begin
        r_count <= r_count - CW'(1);
        if (w_done) begin
          r_y     <= w_result;
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign w_sign1 = r_ux1[W-1];
  assign w_sign2 = r_ux2[W-1];
  assign w_exp1  = r_ux1[W-2 -: EW];
  assign w_exp2  = r_ux2[W-2 -: EW];
  assign w_man1  = r_ux1[MW-1:0];
  assign w_man2  = r_ux2[MW-1:0];
  assign w_mag1  = r_ux1[W-2:0];
  assign w_mag2  = r_ux2[W-2:0];

  // Compare flags: NaN forces false, signed zeros are equal, else sign-magnitude order
  always_comb begin
    w_anyNan   = ((&w_exp1) && (|w_man1)) || ((&w_exp2) && (|w_man2));
    w_bothZero = (w_mag1 == '0) && (w_mag2 == '0);
    w_eq       = !w_anyNan && (w_bothZero || (r_ux1 == r_ux2));
    w_lt       = 1'b0;
    if (!w_anyNan && !w_bothZero) begin
      if (w_sign1 != w_sign2) w_lt = w_sign1;
      else if (!w_sign1)      w_lt = (w_mag1 < w_mag2);
      else                    w_lt = (w_mag1 > w_mag2);
    end
    w_le = w_lt || w_eq;
  end

  // Result select for the op in flight: unit outputs or local sign/compare logic
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_FADD, OP_FSUB: w_result = i_fadd_y;
      OP_FMUL:          w_result = i_fmul_y;
      OP_FDIV:          w_result = i_fdiv_y;
      OP_FSQRT:         w_result = i_fsqrt_y;
      OP_FSGNJ:         w_result = {w_sign2, w_mag1};
      OP_FSGNJN:        w_result = {~w_sign2, w_mag1};
      OP_FSGNJX:        w_result = {w_sign1 ^ w_sign2, w_mag1};
      OP_FEQ:           w_result = {{(W-1){1'b0}}, w_eq};
      OP_FLT:           w_result = {{(W-1){1'b0}}, w_lt};
      OP_FLE:           w_result = {{(W-1){1'b0}}, w_le};
      default:          w_result = '0;
    endcase
  end

endmodule
